ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pipe.sv | 143 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoder control word through ID/EX, EX/MEM and MEM/WB,
// resolves branches/jumps in EX and drives the IF/ID stall and flush strobes.
// Optional feature: define CTRL_PIPE_LOADUSE_EN to enable load-use stall detection;
// when undefined, stall is tied low and the compiler schedules the load delay.
module ctrl_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [13:0] id_ctrl,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        ex_zero,
    output logic [13:0] ex_ctrl,
    output logic [4:0]  ex_wreg,
    output logic        ex_taken,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic        mem_memtoreg,
    output logic        mem_regwrite,
    output logic [4:0]  mem_wreg,
    output logic        wb_memtoreg,
    output logic        wb_regwrite,
    output logic [4:0]  wb_wreg,
    output logic        stall,
    output logic        flush
);

    localparam int unsigned CTRL_W = 14;
    localparam int unsigned REG_W  = 5;
    localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

    typedef struct packed {
        logic       signext;
        logic [1:0] aluop;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       jumpr;
        logic       link;
    } ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    ctrl_t            id_word;
    ctrl_t            ex_q;
    logic [REG_W-1:0] ex_wreg_q;
    mem_ctrl_t        mem_q;
    logic [REG_W-1:0] mem_wreg_q;
    wb_ctrl_t         wb_q;
    logic [REG_W-1:0] wb_wreg_q;
    logic [REG_W-1:0] dest_c;
    logic             loaduse_c;
    logic             bubble_c;

    assign id_word = ctrl_t'(id_ctrl);

    // Destination register select: link beats regdst beats rt.
    always_comb begin
        dest_c = id_rt;
        if (id_word.link) begin
            dest_c = LINK_REG;
        end else if (id_word.regdst) begin
            dest_c = id_rd;
        end
    end

    // Redirect resolution for the instruction in EX.
    assign ex_taken = (ex_q.branch & (ex_zero ^ ex_q.branchne)) | ex_q.jump;
    assign flush    = ex_taken;

`ifdef CTRL_PIPE_LOADUSE_EN
    // Load in EX writing a register the ID instruction may read (rt check is conservative).
    assign loaduse_c = ex_q.memread & ex_q.regwrite & (ex_wreg_q != '0) & id_valid &
                       ((ex_wreg_q == id_rs) | (ex_wreg_q == id_rt));
`else
    logic unused_rs;
    assign unused_rs = ^id_rs;
    assign loaduse_c = 1'b0;
`endif

    // A redirect kills the ID instruction anyway, so flush takes priority over stall.
    assign stall    = loaduse_c & ~flush;
    assign bubble_c = ~id_valid | stall | flush;

    // ID/EX register: capture the ID word or insert a clean bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_wreg_q <= '0;
        end else if (bubble_c) begin
            ex_q      <= '0;
            ex_wreg_q <= '0;
        end else begin
            ex_q      <= id_word;
            ex_wreg_q <= dest_c;
        end
    end

    // EX/MEM and MEM/WB registers advance every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '0;
            mem_wreg_q <= '0;
            wb_q       <= '0;
            wb_wreg_q  <= '0;
        end else begin
            mem_q      <= '{memread:  ex_q.memread,  memwrite: ex_q.memwrite,
                            memtoreg: ex_q.memtoreg, regwrite: ex_q.regwrite};
            mem_wreg_q <= ex_wreg_q;
            wb_q       <= '{memtoreg: mem_q.memtoreg, regwrite: mem_q.regwrite};
            wb_wreg_q  <= mem_wreg_q;
        end
    end

    assign ex_ctrl      = CTRL_W'(ex_q);
    assign ex_wreg      = ex_wreg_q;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_wreg     = mem_wreg_q;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_wreg      = wb_wreg_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed ID vectors with hand-computed EX results;
// MEM/WB expectations are the EX expectations of one and two cycles earlier.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [13:0] id_ctrl = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        ex_zero = 1'b0;
    logic [13:0] ex_ctrl;
    logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
    logic        ex_taken, stall, flush;
    logic        mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic        wb_memtoreg, wb_regwrite;

    // signext aluop alusrc memread memwrite memtoreg regwrite regdst branch branchne jump jumpr link
    localparam logic [13:0] NOP = 14'b0_00_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] LW  = 14'b1_00_1_1_0_1_1_0_0_0_0_0_0;
    localparam logic [13:0] ADD = 14'b0_10_0_0_0_0_1_1_0_0_0_0_0;
    localparam logic [13:0] SW  = 14'b1_00_1_0_1_0_0_0_0_0_0_0_0;
    localparam logic [13:0] BEQ = 14'b0_01_0_0_0_0_0_0_1_0_0_0_0;
    localparam logic [13:0] BNE = 14'b0_01_0_0_0_0_0_0_1_1_0_0_0;
    localparam logic [13:0] JAL = 14'b0_00_0_0_0_0_1_0_0_0_1_0_1;

`ifdef CTRL_PIPE_LOADUSE_EN
    localparam logic LU = 1'b1;
`else
    localparam logic LU = 1'b0;
`endif

    typedef struct packed {
        logic [13:0] ctrl;
        logic [4:0]  wreg;
        logic        taken;
        logic        stall;
        logic        flush;
    } ex_exp_t;

    typedef struct packed {
        ex_exp_t ex;
        ex_exp_t mem;
        ex_exp_t wb;
    } exp_t;

    exp_t    sb[$];
    ex_exp_t hist1 = '0, hist2 = '0;
    int      total = 0;
    int      bad = 0;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg), .ex_taken(ex_taken),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
        .stall(stall), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // mode: 0 run, 1 reset held from start of cycle, 2 reset pulsed mid-cycle
    task automatic step(input int mode, input logic v, input logic [13:0] c,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic z, input logic [13:0] ec, input logic [4:0] ew,
                        input logic et, input logic es, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        if (mode == 1) rst_n = 1'b0;
        else if (mode == 0) rst_n = 1'b1;
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
        if (mode == 2) begin
            #1 rst_n = 1'b0;
        end
        e.ex = '{ctrl: ec, wreg: ew, taken: et, stall: es, flush: ef};
        if (mode != 0) begin
            e.mem = '0;
            e.wb  = '0;
            hist2 = '0;
        end else begin
            e.mem = hist1;
            e.wb  = hist2;
            hist2 = hist1;
        end
        hist1 = e.ex;
        sb.push_back(e);
    endtask

    // Monitor: compare every DUT output group against the queued expectation.
    initial begin
        exp_t e;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_ctrl",  cyc, ex_ctrl, e.ex.ctrl);
                chk("ex_wreg",  cyc, 14'(ex_wreg), 14'(e.ex.wreg));
                chk("ex_taken", cyc, 14'(ex_taken), 14'(e.ex.taken));
                chk("stall",    cyc, 14'(stall), 14'(e.ex.stall));
                chk("flush",    cyc, 14'(flush), 14'(e.ex.flush));
                chk("mem_ctrl", cyc, 14'({mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite}),
                    14'({e.mem.ctrl[9], e.mem.ctrl[8], e.mem.ctrl[7], e.mem.ctrl[6]}));
                chk("mem_wreg", cyc, 14'(mem_wreg), 14'(e.mem.wreg));
                chk("wb_ctrl",  cyc, 14'({wb_memtoreg, wb_regwrite}),
                    14'({e.wb.ctrl[7], e.wb.ctrl[6]}));
                chk("wb_wreg",  cyc, 14'(wb_wreg), 14'(e.wb.wreg));
                cyc++;
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        // reset held with lw in ID, then release: lw reaches EX one cycle later
        step(1, 1, LW,  5'd1, 5'd8, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 1, LW,  5'd1, 5'd8, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        // add reading $8 behind lw $8
        step(0, 1, ADD, 5'd8, 5'd9, 5'd10, 0, LW, 5'd8, 0, LU, 0);
`ifdef CTRL_PIPE_LOADUSE_EN
        step(0, 1, ADD, 5'd8, 5'd9, 5'd10, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, ADD, 5'd10, 0, 0, 0);
`else
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, ADD, 5'd10, 0, 0, 0);
`endif
        // jal: links to $31, redirects, kills the following ID instruction
        step(0, 1, JAL, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 1, ADD, 5'd1, 5'd2, 5'd3, 0, JAL, 5'd31, 1, 0, 1);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        // beq taken (zero=1), then beq not taken (zero=0)
        step(0, 1, BEQ, 5'd4, 5'd5, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 1, ADD, 5'd1, 5'd2, 5'd3, 1, BEQ, 5'd5, 1, 0, 1);
        step(0, 1, BEQ, 5'd4, 5'd5, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 1, BNE, 5'd4, 5'd5, 5'd0, 0, BEQ, 5'd5, 0, 0, 0);
        // bne taken (zero=0), then bne not taken (zero=1)
        step(0, 1, ADD, 5'd1, 5'd2, 5'd3, 0, BNE, 5'd5, 1, 0, 1);
        step(0, 1, BNE, 5'd4, 5'd5, 5'd0, 1, NOP, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 1, BNE, 5'd5, 0, 0, 0);
        // lw into $0 never stalls a consumer of $0
        step(0, 1, LW,  5'd1, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 1, ADD, 5'd0, 5'd0, 5'd7, 0, LW, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, ADD, 5'd7, 0, 0, 0);
        // rt-only match stalls; then build sw/add/lw in EX/MEM/WB and pulse reset
        step(0, 1, LW,  5'd2, 5'd9, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 1, ADD, 5'd4, 5'd9, 5'd11, 0, LW, 5'd9, 0, LU, 0);
`ifdef CTRL_PIPE_LOADUSE_EN
        step(0, 1, ADD, 5'd4, 5'd9, 5'd11, 0, NOP, 5'd0, 0, 0, 0);
`endif
        step(0, 1, SW,  5'd5, 5'd6, 5'd0, 0, ADD, 5'd11, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, SW, 5'd6, 0, 0, 0);
        step(2, 0, NOP, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 0, NOP, 5'd0, 0, 0, 0);
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
